// File: rtl/cdda_pkg.sv
// Shared constants for the CD-DA serializer.
// Register map, CTRL/STATUS bit positions, frame width.
package cdda_pkg;

  localparam int FRAME_W = 32;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_LEVEL  = 2'd3;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_IRQEN = 1;
  localparam int CTRL_FLUSH = 7;

  localparam int ST_EMPTY    = 0;
  localparam int ST_FULL     = 1;
  localparam int ST_UNDERRUN = 2;
  localparam int ST_OVERFLOW = 3;
  localparam int ST_LOW      = 4;

endpackage

// File: rtl/cdda_fifo.sv
// Synchronous FIFO of stereo frames, show-ahead read.
// Ports: clk, nrst, push/wdata, pop/rdata, flush, full, empty, count.
module cdda_fifo
  import cdda_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               push,
  input  logic [FRAME_W-1:0] wdata,
  input  logic               pop,
  output logic [FRAME_W-1:0] rdata,
  input  logic               flush,
  output logic               full,
  output logic               empty,
  output logic [DEPTH_LOG2:0] count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [FRAME_W-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty = (count == '0);
  assign full  = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign rdata = mem[rptr];

  // A pop frees a slot in the same cycle, so a push into a full
  // FIFO is still taken when it coincides with a pop.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/cdda_serializer.sv
// CD-DA output stage: byte window -> frame FIFO -> BCLK/LRCK/SDAT.
// Ports: AVR SRAM bus (sram_*), irq, serial audio (bclk, lrck, sdat).
module cdda_serializer
  import cdda_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int BCLK_HALF  = 16,
  parameter int IRQ_LEVEL  = 4
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [1:0] sram_a,
  input  logic [7:0] sram_d_in,
  output logic [7:0] sram_d_out,
  input  logic       sram_cs,
  input  logic       sram_oe,
  input  logic       sram_we,
  output logic       sram_wait,
  output logic       irq,
  output logic       bclk,
  output logic       lrck,
  output logic       sdat
);

  localparam int HW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

  logic                wr_prev;
  logic                wr_hit;
  logic                wr;
  logic                wr_data;
  logic                wr_ctrl;
  logic                wr_stat;
  logic                flush;
  logic                en;
  logic                irqen;
  logic                udr;
  logic                ovf;
  logic [1:0]          bidx;
  logic [7:0]          b0;
  logic [7:0]          b1;
  logic [7:0]          b2;
  logic                frame_done;
  logic [FRAME_W-1:0]  frame_w;
  logic [FRAME_W-1:0]  rdata;
  logic                full;
  logic                empty;
  logic [DEPTH_LOG2:0] count;
  logic                low;
  logic                phase0;
  logic                pop_ok;
  logic [HW-1:0]       hcnt;
  logic [5:0]          slot;
  logic [FRAME_W-1:0]  word;
  logic [FRAME_W-1:0]  load;
  logic [FRAME_W-1:0]  cur;

  // The AVR strobe spans two clocks; take only its first cycle.
  assign wr_hit  = sram_cs & sram_we;
  assign wr      = wr_hit & ~wr_prev;
  assign wr_data = wr & (sram_a == REG_DATA);
  assign wr_ctrl = wr & (sram_a == REG_CTRL);
  assign wr_stat = wr & (sram_a == REG_STATUS);
  assign flush   = wr_ctrl & sram_d_in[CTRL_FLUSH];

  // Byte order L-lo, L-hi, R-lo, R-hi; the 4th byte is live on the bus.
  assign frame_done = wr_data & (bidx == 2'd3);
  assign frame_w    = {b1, b0, sram_d_in, b2};

  assign low       = (count <= (DEPTH_LOG2+1)'(IRQ_LEVEL));
  assign phase0    = en & (slot == '0) & (hcnt == '0);
  assign pop_ok    = phase0 & ~empty;
  assign load      = empty ? '0 : rdata;
  assign cur       = phase0 ? load : word;
  assign sram_wait = 1'b0;

  cdda_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (frame_done),
    .wdata (frame_w),
    .pop   (phase0),
    .rdata (rdata),
    .flush (flush),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_prev <= 1'b0;
      en      <= 1'b0;
      irqen   <= 1'b0;
      udr     <= 1'b0;
      ovf     <= 1'b0;
      bidx    <= 2'd0;
      b0      <= 8'd0;
      b1      <= 8'd0;
      b2      <= 8'd0;
      irq     <= 1'b0;
    end else begin
      wr_prev <= wr_hit;
      irq     <= irqen & en & low;
      if (wr_ctrl) begin
        en    <= sram_d_in[CTRL_EN];
        irqen <= sram_d_in[CTRL_IRQEN];
      end
      if (flush) begin
        bidx <= 2'd0;
      end else if (wr_data) begin
        unique case (bidx)
          2'd0:    b0 <= sram_d_in;
          2'd1:    b1 <= sram_d_in;
          2'd2:    b2 <= sram_d_in;
          default: ;
        endcase
        bidx <= bidx + 2'd1;
      end
      if (phase0 && empty)
        udr <= 1'b1;
      else if (wr_stat && sram_d_in[ST_UNDERRUN])
        udr <= 1'b0;
      if (frame_done && full && !pop_ok)
        ovf <= 1'b1;
      else if (wr_stat && sram_d_in[ST_OVERFLOW])
        ovf <= 1'b0;
    end
  end

  // slot counts BCLK half-periods: slot[0] is bclk, slot[5:1] the
  // bit number within the frame, slot[5] the channel.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hcnt <= '0;
      slot <= '0;
      word <= '0;
      bclk <= 1'b0;
      lrck <= 1'b0;
      sdat <= 1'b0;
    end else if (!en) begin
      hcnt <= '0;
      slot <= '0;
      word <= '0;
      bclk <= 1'b0;
      lrck <= 1'b0;
      sdat <= 1'b0;
    end else begin
      bclk <= slot[0];
      lrck <= slot[5];
      sdat <= cur[~slot[5:1]];
      if (phase0) word <= load;
      if (hcnt == HW'(BCLK_HALF-1)) begin
        hcnt <= '0;
        slot <= slot + 6'd1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  always_comb begin
    sram_d_out = 8'd0;
    if (sram_cs && sram_oe) begin
      unique case (1'b1)
        sram_a == REG_DATA:   sram_d_out = 8'd0;
        sram_a == REG_CTRL:   sram_d_out = {6'd0, irqen, en};
        sram_a == REG_STATUS: sram_d_out = {3'd0, low, ovf, udr, full, empty};
        sram_a == REG_LEVEL:  sram_d_out = 8'(count);
        default:              sram_d_out = 8'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_cdda_serializer.sv
// Scoreboard bench for cdda_serializer.
// Model FIFO of expected frames; serial monitor pops and compares.
module tb_cdda_serializer;

  localparam int H = 16;

  logic       clk;
  logic       nrst;
  logic [1:0] sram_a;
  logic [7:0] sram_d_in;
  logic [7:0] sram_d_out;
  logic       sram_cs;
  logic       sram_oe;
  logic       sram_we;
  logic       sram_wait;
  logic       irq;
  logic       bclk;
  logic       lrck;
  logic       sdat;

  cdda_serializer dut (
    .clk        (clk),
    .nrst       (nrst),
    .sram_a     (sram_a),
    .sram_d_in  (sram_d_in),
    .sram_d_out (sram_d_out),
    .sram_cs    (sram_cs),
    .sram_oe    (sram_oe),
    .sram_we    (sram_we),
    .sram_wait  (sram_wait),
    .irq        (irq),
    .bclk       (bclk),
    .lrck       (lrck),
    .sdat       (sdat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int frames = 0;
  bit en_model = 0;
  logic [31:0] mfifo[$];
  logic [7:0]  bbuf[$];
  bit          movf = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input bit ok, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Serial monitor: a new frame starts at the first bclk rise;
  // its expected value is the head of the model FIFO, or 0 on underrun.
  int          nbits = 0;
  int          last_rise = -1;
  logic        prev_bclk = 0;
  logic [31:0] got;
  logic [31:0] expf;

  always @(negedge clk) begin
    if (!nrst || !en_model) begin
      nbits     = 0;
      last_rise = -1;
      prev_bclk = 0;
    end else begin
      if (bclk && !prev_bclk) begin
        if (nbits == 0)
          expf = (mfifo.size() > 0) ? mfifo.pop_front() : 32'd0;
        if (last_rise >= 0)
          chk((cyc - last_rise) == 2*H, "bit_period", cyc - last_rise, 2*H);
        chk(lrck == (nbits >= 16), "lrck", {31'd0, lrck}, {31'd0, nbits >= 16});
        got[31-nbits] = sdat;
        nbits++;
        if (nbits == 32) begin
          chk(got == expf, "frame", got, expf);
          frames++;
          nbits = 0;
        end
        last_rise = cyc;
      end
      prev_bclk = bclk;
    end
  end

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    sram_a = a; sram_d_in = d; sram_cs = 1; sram_we = 1;
    @(posedge clk); @(posedge clk); #1;
    sram_cs = 0; sram_we = 0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    @(posedge clk); #1;
    sram_a = a; sram_cs = 1; sram_oe = 1;
    #1 d = sram_d_out;
    sram_cs = 0; sram_oe = 0;
  endtask

  task automatic rd_chk(input logic [1:0] a, input logic [7:0] e,
                        input string name);
    logic [7:0] v;
    rd(a, v);
    chk(v == e, name, {24'd0, v}, {24'd0, e});
  endtask

  function automatic void model_byte(input logic [7:0] b);
    logic [31:0] f;
    bbuf.push_back(b);
    if (bbuf.size() == 4) begin
      f = {bbuf[1], bbuf[0], bbuf[3], bbuf[2]};
      if (mfifo.size() < 16) mfifo.push_back(f);
      else movf = 1;
      bbuf.delete();
    end
  endfunction

  task automatic put_byte(input logic [7:0] b);
    wr(2'd0, b);
    model_byte(b);
  endtask

  task automatic put_frame(input logic [31:0] f);
    put_byte(f[23:16]);
    put_byte(f[31:24]);
    put_byte(f[7:0]);
    put_byte(f[15:8]);
  endtask

  function automatic logic [7:0] st(input bit udr);
    int n;
    n = mfifo.size();
    return {3'd0, n <= 4, movf, udr, n == 16, n == 0};
  endfunction

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames < target && n < 12000) begin
      @(posedge clk);
      n++;
    end
    chk(frames >= target, "frame_wait", frames, target);
  endtask

  initial begin
    logic [7:0] v;
    int n;
    nrst = 0; sram_a = 0; sram_d_in = 0;
    sram_cs = 0; sram_oe = 0; sram_we = 0;
    repeat (3) @(posedge clk);
    #2 nrst = 1;
    @(negedge clk);
    chk({bclk, lrck, sdat, irq, sram_wait} == 5'd0, "reset_outs",
        {27'd0, bclk, lrck, sdat, irq, sram_wait}, 0);
    chk(sram_d_out == 8'd0, "idle_dout", {24'd0, sram_d_out}, 0);
    rd_chk(2'd1, 8'h00, "reset_ctrl");
    rd_chk(2'd2, 8'h11, "reset_status");
    rd_chk(2'd3, 8'h00, "reset_level");
    rd_chk(2'd0, 8'h00, "data_read");

    // single frame, then underrun
    put_byte(8'h34); put_byte(8'h12); put_byte(8'h78); put_byte(8'h56);
    rd_chk(2'd3, 8'd1, "level_one");
    en_model = 1;
    wr(2'd1, 8'h01);
    rd_chk(2'd3, 8'd0, "level_popped");
    wait_frames(2);
    en_model = 0;
    wr(2'd1, 8'h00);
    rd_chk(2'd2, st(1), "underrun_set");
    wr(2'd2, 8'h04);
    rd_chk(2'd2, st(0), "underrun_clr");

    // irq threshold
    for (int i = 0; i < 6; i++) put_frame($urandom);
    rd_chk(2'd3, 8'd6, "level_six");
    en_model = 1;
    wr(2'd1, 8'h03);
    chk(irq == 1'b0, "irq_high_level", {31'd0, irq}, 0);
    rd_chk(2'd3, 8'd5, "level_five");
    sram_a = 2'd3; sram_cs = 1; sram_oe = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sram_d_out != 8'd4 && n < 3000);
    chk(sram_d_out == 8'd4, "level_reach4", {24'd0, sram_d_out}, 4);
    chk(irq == 1'b0, "irq_latency", {31'd0, irq}, 0);
    @(negedge clk);
    chk(irq == 1'b1, "irq_assert", {31'd0, irq}, 1);
    sram_cs = 0; sram_oe = 0;
    put_frame($urandom);
    chk(irq == 1'b0, "irq_deassert", {31'd0, irq}, 0);
    rd_chk(2'd3, 8'd5, "level_push5");
    wait_frames(9);
    en_model = 0;
    wr(2'd1, 8'h00);
    wr(2'd2, 8'h04);

    // overflow and flush
    for (int i = 0; i < 17; i++) put_frame($urandom);
    rd_chk(2'd3, 8'd16, "level_full");
    rd_chk(2'd2, st(0), "status_full_ovf");
    put_byte(8'h5A);
    wr(2'd1, 8'h80);
    mfifo.delete();
    bbuf.delete();
    rd_chk(2'd3, 8'd0, "level_flushed");
    rd_chk(2'd2, st(0), "status_flushed");
    rd_chk(2'd1, 8'h00, "flush_reads0");
    wr(2'd2, 8'h08);
    movf = 0;
    rd_chk(2'd2, st(0), "ovf_clr");
    put_frame($urandom);
    rd_chk(2'd3, 8'd1, "level_after_flush");
    en_model = 1;
    wr(2'd1, 8'h01);
    wait_frames(10);
    en_model = 0;
    wr(2'd1, 8'h00);

    // held write strobe counts once
    @(posedge clk); #1;
    sram_a = 2'd0; sram_d_in = 8'hAA; sram_cs = 1; sram_we = 1;
    repeat (4) @(posedge clk);
    #1 sram_cs = 0; sram_we = 0;
    model_byte(8'hAA);
    rd_chk(2'd3, 8'd0, "hold_level0");
    put_byte(8'hBB); put_byte(8'hCC);
    rd_chk(2'd3, 8'd0, "hold_level0b");
    put_byte(8'hDD);
    rd_chk(2'd3, 8'd1, "hold_level1");
    en_model = 1;
    wr(2'd1, 8'h01);
    wait_frames(11);
    en_model = 0;
    wr(2'd1, 8'h00);

    // reset mid-frame
    put_frame(32'hFFFF_FFFF);
    en_model = 1;
    wr(2'd1, 8'h01);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bclk && n < 200);
    chk({bclk, sdat} == 2'b11, "mid_frame_active", {30'd0, bclk, sdat}, 3);
    en_model = 0;
    nrst = 0;
    #1;
    chk({bclk, lrck, sdat, irq} == 4'd0, "async_reset_outs",
        {28'd0, bclk, lrck, sdat, irq}, 0);
    #5 nrst = 1;
    mfifo.delete();
    rd_chk(2'd1, 8'h00, "rst_ctrl");
    rd_chk(2'd3, 8'h00, "rst_level");
    rd_chk(2'd2, 8'h11, "rst_status");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
